axis_lane_accumulator: RTL and testbench
========================================

// Module: axis_lane_accumulator
// PURPOSE
// - AXI-Stream reduction block: sums LANES unsigned DATA_W lanes per input beat and accumulates beats into one ACC_W result per packet.
// - Packet ends on s_axis_tlast or after MAX_BEATS beats, whichever comes first; the result is emitted on a master AXI-Stream port.
// - Sits between a VIP-driven stimulus stream and the scoreboard; a checksum/sum source for the patched-VIP test benches.
// PARAMETERS
// - DATA_W     32  width of one lane, unsigned
// - LANES      2   lanes per beat; s_axis_tdata = LANES*DATA_W; lane 0 = bits [DATA_W-1:0]
// - ACC_W      32  accumulator/result width
// - MAX_BEATS  10  forced packet termination count, >=1
// - CNT_W      $clog2(MAX_BEATS+1)  beat-counter width (derived, do not override)
// PORTS
// - aclk           in   1              single clock, all logic rising-edge
// - areset         in   1              asynchronous, active-high reset
// - s_axis_tdata   in   LANES*DATA_W   input lanes
// - s_axis_tvalid  in   1              input beat valid
// - s_axis_tready  out  1              input beat accepted when valid&ready
// - s_axis_tlast   in   1              last beat of packet
// - m_axis_tdata   out  ACC_W          packet sum
// - m_axis_tvalid  out  1              result valid
// - m_axis_tready  in   1              result consumed when valid&ready
// - m_axis_tuser   out  CNT_W+1        {overflow, beat_count} of the emitted packet
// BEHAVIOUR
// - Reset (async assert, sync deassert by system): state=IDLE, acc=0, cnt=0, s_axis_tready=0 during reset then 1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0.
// - FSM IDLE -> ACCUM on first accepted beat; ACCUM -> OUT on accepted terminating beat; OUT -> IDLE on m handshake.
// - Single-beat packet (tlast on first beat, or MAX_BEATS=1): IDLE -> OUT directly.
// - Terminating beat: tlast=1 OR cnt+1==MAX_BEATS; tlast after forced termination starts a new packet, no error.
// - s_axis_tready = 1 in IDLE/ACCUM, 0 in OUT (no overlap; one result in flight).
// - Per accepted beat: lane_sum = sum of lanes, width DATA_W+$clog2(LANES); acc_next = acc + zero-ext/truncated lane_sum.
// - Latency: m_axis_tvalid rises the cycle after the terminating beat handshake; tdata/tuser stable while valid&!ready.
// - On entering OUT with a new packet, acc and cnt restart from 0 (first beat of next packet loads, not adds).
// - overflow bit = any carry out of ACC_W (or lane_sum truncation) during the packet; sticky per packet.
// - m_axis_tuser beat_count = number of beats in the packet (1..MAX_BEATS).
// - Reset mid-packet: partial sum discarded, no output emitted.
// - s_axis_tvalid=0 gaps inside a packet hold acc/cnt.
// CONFIGURATION
// - Macro AXIS_ACC_SATURATE_EN.
// - Defined: on overflow acc clamps to {ACC_W{1'b1}} and stays there for the rest of the packet; overflow bit set.
// - Undefined: acc wraps modulo 2^ACC_W; overflow bit still reported.
// STRUCTURE
// - Package axis_acc_pkg: state enum (IDLE, ACCUM, OUT), function lane_sum_w(DATA_W,LANES), default-width localparams.
// - Sub-module lane_adder_tree: combinational, parametrised LANES/DATA_W, balanced tree, output width lane_sum_w.
// - Top: FSM, counter, accumulator, output register.
// TESTING
// - DATA_W=32,LANES=2: beats {1,2},{3,4},{5,6} tlast on 3rd -> tdata=21, tuser={0,3}, valid 1 cycle after 3rd beat.
// - No tlast, 12 beats of {1,1}, MAX_BEATS=10 -> result 20 cnt 10, then second packet result 4 cnt 2 (tlast on beat 12).
// - Beats {32'hFFFF_FFFF,1},{1,0} tlast -> wrap: tdata=1 overflow=1; with AXIS_ACC_SATURATE_EN: tdata=32'hFFFF_FFFF overflow=1.
// - Hold m_axis_tready=0 for 5 cycles -> s_axis_tready=0, tdata/tuser stable, no input beat lost; release -> next packet sums correctly.
// - Assert areset after 2 beats {7,7},{7,7} -> all outputs 0; next packet {2,3} tlast -> tdata=5, tuser={0,1}.
// - Single-beat packet {10,20} tlast, random tvalid gaps and tready backpressure over 1000 packets -> matches reference model.

Source files
------------

// File: rtl/axis_acc_pkg.sv
// rtl/axis_acc_pkg.sv - shared state type, default widths and lane-sum width helper for axis_lane_accumulator
package axis_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } acc_state_e;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_LANES     = 2;
   localparam int DEF_ACC_W     = 32;
   localparam int DEF_MAX_BEATS = 10;

   // Width that holds the full sum of all lanes of one beat without loss.
   function automatic int lane_sum_w(input int data_w, input int lanes);
      return data_w + $clog2(lanes);
   endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// rtl/lane_adder_tree.sv - combinational balanced adder tree summing LANES unsigned DATA_W lanes
module lane_adder_tree
   import axis_acc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LANES  = DEF_LANES,
   localparam int SUM_W = lane_sum_w(DATA_W, LANES)
) (
   input  logic [LANES*DATA_W-1:0] lanes,
   output logic [SUM_W-1:0]        sum
);

   localparam int LEVELS = $clog2(LANES);
   localparam int NODES  = 1 << LEVELS;

   logic [SUM_W-1:0] node [NODES];

   // Leaves are padded to a power of two; each level halves the live node count in place.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         node[i] = SUM_W'(lanes[i*DATA_W +: DATA_W]);
      end
      for (int i = LANES; i < NODES; i++) begin
         node[i] = '0;
      end
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         for (int i = 0; i < (NODES >> (lvl + 1)); i++) begin
            node[i] = node[2*i] + node[2*i+1];
         end
      end
      sum = node[0];
   end

endmodule

// File: rtl/axis_lane_accumulator.sv
// rtl/axis_lane_accumulator.sv - per-packet lane-sum accumulator, stream in / one result out; AXIS_ACC_SATURATE_EN clamps on overflow
module axis_lane_accumulator
   import axis_acc_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LANES     = DEF_LANES,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [LANES*DATA_W-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [ACC_W-1:0]        m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [CNT_W:0]          m_axis_tuser
);

   localparam int               SUM_W   = lane_sum_w(DATA_W, LANES);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

   acc_state_e       state;
   acc_state_e       state_next;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             ovf;
   logic             ovf_next;
   logic             beat_ovf;
   logic             trunc_ovf;
   logic [SUM_W-1:0] lane_sum;
   logic [ACC_W-1:0] addend;
   logic [ACC_W:0]   sum_wide;
   logic             s_ready_q;
   logic             s_hs;
   logic             m_hs;
   logic             term;
   logic [ACC_W-1:0] m_data_q;
   logic [CNT_W:0]   m_user_q;

   lane_adder_tree #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_lane_adder_tree (
      .lanes (s_axis_tdata),
      .sum   (lane_sum)
   );

   // A lane sum wider than the accumulator loses its upper bits; that loss counts as overflow.
   generate
      if (SUM_W > ACC_W) begin : g_trunc
         assign addend    = lane_sum[ACC_W-1:0];
         assign trunc_ovf = |lane_sum[SUM_W-1:ACC_W];
      end else begin : g_ext
         assign addend    = ACC_W'(lane_sum);
         assign trunc_ovf = 1'b0;
      end
   endgenerate

   assign s_hs     = s_axis_tvalid & s_ready_q;
   assign m_hs     = (state == OUT) & m_axis_tready;
   assign cnt_inc  = cnt + 1'b1;
   assign term     = s_axis_tlast | (cnt_inc == MAX_CNT);
   assign sum_wide = {1'b0, acc} + {1'b0, addend};
   assign beat_ovf = sum_wide[ACC_W] | trunc_ovf;
   assign ovf_next = ovf | beat_ovf;

`ifdef AXIS_ACC_SATURATE_EN
   // Once clamped, the sticky flag keeps the accumulator pinned until the packet ends.
   assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
   assign acc_next = sum_wide[ACC_W-1:0];
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (s_hs) state_next = term ? OUT : ACCUM;
         ACCUM:   if (s_hs && term) state_next = OUT;
         OUT:     if (m_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // acc/cnt/ovf are cleared as the result is captured, so the next packet's first beat loads.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         s_ready_q <= 1'b0;
         m_data_q  <= '0;
         m_user_q  <= '0;
      end else begin
         s_ready_q <= (state_next != OUT);
         if (s_hs) begin
            if (term) begin
               acc      <= '0;
               cnt      <= '0;
               ovf      <= 1'b0;
               m_data_q <= acc_next;
               m_user_q <= {ovf_next, cnt_inc};
            end else begin
               acc <= acc_next;
               cnt <= cnt_inc;
               ovf <= ovf_next;
            end
         end
      end
   end

   assign s_axis_tready = s_ready_q;
   assign m_axis_tvalid = (state == OUT);
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_axis_lane_accumulator.sv
// tb/tb_axis_lane_accumulator.sv - self-checking bench: vector table, corner sequences, randomized packets vs sum model
module tb_axis_lane_accumulator;

   localparam int DATA_W    = 32;
   localparam int LANES     = 2;
   localparam int ACC_W     = 32;
   localparam int MAX_BEATS = 10;
   localparam int CNT_W     = 4;
   localparam int N_RAND    = 1000;
   localparam int RAND_CYC  = 80000;

`ifdef AXIS_ACC_SATURATE_EN
   localparam logic [31:0] OVF_RES_1 = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_RES_5 = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] OVF_RES_1 = 32'd1;
   localparam logic [31:0] OVF_RES_5 = 32'd5;
`endif

   logic                    aclk = 1'b0;
   logic                    areset;
   logic [LANES*DATA_W-1:0] s_axis_tdata;
   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic                    s_axis_tlast;
   logic [ACC_W-1:0]        m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic [CNT_W:0]          m_axis_tuser;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int              n;
      logic [3:0][63:0] d;
      logic [31:0]     ed;
      logic [4:0]      eu;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  u;
   } exp_t;

   vec_t        vecs [6];
   exp_t        exp_q [$];
   logic [63:0] m_total = '0;
   int          m_cnt = 0;
   bit          prod_done = 1'b0;

   always #5 aclk = ~aclk;

   axis_lane_accumulator #(
      .DATA_W    (DATA_W),
      .LANES     (LANES),
      .ACC_W     (ACC_W),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tuser  (m_axis_tuser)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for handshake", nm);
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat was accepted.
   task automatic send_beat(input logic [63:0] d, input logic l);
      int guard = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = l;
      @(negedge aclk);
      while (!s_axis_tready && guard < 500) begin
         guard++;
         @(negedge aclk);
      end
      if (guard >= 500) timeout_fail("send_beat");
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic collect(input logic [31:0] ed, input logic [4:0] eu, input string nm);
      int guard = 0;
      @(negedge aclk);
      while (!(m_axis_tvalid && m_axis_tready) && guard < 500) begin
         guard++;
         @(negedge aclk);
      end
      if (guard >= 500) begin
         timeout_fail(nm);
      end else begin
         chk({nm, "_data"}, 64'(m_axis_tdata), 64'(ed));
         chk({nm, "_user"}, 64'(m_axis_tuser), 64'(eu));
      end
      @(posedge aclk);
      #1;
   endtask

   // Reference: a packet's result is its true lane total; it overflowed iff that total reaches 2^ACC_W.
   task automatic model_beat(input logic [63:0] d, input logic l);
      exp_t e;
      logic ov;
      m_total = m_total + 64'(d[31:0]) + 64'(d[63:32]);
      m_cnt++;
      if (l || m_cnt == MAX_BEATS) begin
         ov = (m_total >= 64'h1_0000_0000);
`ifdef AXIS_ACC_SATURATE_EN
         e.d = ov ? 32'hFFFF_FFFF : m_total[31:0];
`else
         e.d = m_total[31:0];
`endif
         e.u = {ov, 4'(m_cnt)};
         exp_q.push_back(e);
         m_total = '0;
         m_cnt   = 0;
      end
   endtask

   function automatic logic [31:0] rand_lane();
      case ($urandom_range(0, 7))
         0:       return $urandom;
         1:       return 32'hFFFF_FFFF;
         default: return 32'($urandom_range(0, 1000));
      endcase
   endfunction

   initial begin
      #950000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0].n = 3; vecs[0].d = '0;
      vecs[0].d[0] = {32'd2, 32'd1}; vecs[0].d[1] = {32'd4, 32'd3}; vecs[0].d[2] = {32'd6, 32'd5};
      vecs[0].ed = 32'd21; vecs[0].eu = 5'b0_0011;
      vecs[1].n = 2; vecs[1].d = '0;
      vecs[1].d[0] = {32'd1, 32'hFFFF_FFFF}; vecs[1].d[1] = {32'd0, 32'd1};
      vecs[1].ed = OVF_RES_1; vecs[1].eu = 5'b1_0010;
      vecs[2].n = 1; vecs[2].d = '0;
      vecs[2].d[0] = {32'd20, 32'd10};
      vecs[2].ed = 32'd30; vecs[2].eu = 5'b0_0001;
      vecs[3].n = 1; vecs[3].d = '0;
      vecs[3].ed = 32'd0; vecs[3].eu = 5'b0_0001;
      vecs[4].n = 3; vecs[4].d = '0;
      vecs[4].d[0] = {32'd0, 32'h8000_0000}; vecs[4].d[1] = {32'h8000_0000, 32'd0}; vecs[4].d[2] = {32'd0, 32'd5};
      vecs[4].ed = OVF_RES_5; vecs[4].eu = 5'b1_0011;
      vecs[5].n = 1; vecs[5].d = '0;
      vecs[5].d[0] = {32'd0, 32'hFFFF_FFFF};
      vecs[5].ed = 32'hFFFF_FFFF; vecs[5].eu = 5'b0_0001;

      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_m_data", 64'(m_axis_tdata), 64'd0);
      chk("rst_m_user", 64'(m_axis_tuser), 64'd0);
      chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
      areset = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      chk("post_rst_s_ready", 64'(s_axis_tready), 64'd1);
      chk("post_rst_m_valid", 64'(m_axis_tvalid), 64'd0);

      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < vecs[i].n; b++) begin
            send_beat(vecs[i].d[b], b == vecs[i].n - 1);
         end
         chk($sformatf("vec%0d_latency", i), 64'(m_axis_tvalid), 64'd1);
         chk($sformatf("vec%0d_s_ready", i), 64'(s_axis_tready), 64'd0);
         chk($sformatf("vec%0d_data", i), 64'(m_axis_tdata), 64'(vecs[i].ed));
         chk($sformatf("vec%0d_user", i), 64'(m_axis_tuser), 64'(vecs[i].eu));
         @(posedge aclk);
         #1;
         chk($sformatf("vec%0d_valid_drop", i), 64'(m_axis_tvalid), 64'd0);
      end

      fork
         begin
            for (int b = 0; b < 12; b++) send_beat({32'd1, 32'd1}, b == 11);
         end
         begin
            collect(32'd20, 5'b0_1010, "forced");
            collect(32'd4, 5'b0_0010, "after_forced");
         end
      join

      m_axis_tready = 1'b0;
      send_beat({32'd2, 32'd1}, 1'b0);
      send_beat({32'd4, 32'd3}, 1'b1);
      fork
         begin
            send_beat({32'd5, 32'd5}, 1'b0);
            send_beat({32'd1, 32'd1}, 1'b1);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               @(negedge aclk);
               chk("bp_s_ready", 64'(s_axis_tready), 64'd0);
               chk("bp_valid", 64'(m_axis_tvalid), 64'd1);
               chk("bp_data", 64'(m_axis_tdata), 64'd10);
               chk("bp_user", 64'(m_axis_tuser), 64'b0_0010);
            end
            @(posedge aclk);
            #1;
            m_axis_tready = 1'b1;
            collect(32'd10, 5'b0_0010, "bp_release");
            collect(32'd12, 5'b0_0010, "bp_next");
         end
      join

      send_beat({32'd7, 32'd7}, 1'b0);
      send_beat({32'd7, 32'd7}, 1'b0);
      areset = 1'b1;
      #2;
      chk("midrst_valid", 64'(m_axis_tvalid), 64'd0);
      chk("midrst_data", 64'(m_axis_tdata), 64'd0);
      chk("midrst_user", 64'(m_axis_tuser), 64'd0);
      chk("midrst_s_ready", 64'(s_axis_tready), 64'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      repeat (3) begin
         @(posedge aclk);
         #1;
         chk("midrst_no_output", 64'(m_axis_tvalid), 64'd0);
      end
      fork
         send_beat({32'd3, 32'd2}, 1'b1);
         collect(32'd5, 5'b0_0001, "after_rst");
      join

      fork
         begin
            for (int p = 0; p < N_RAND; p++) begin
               int len;
               len = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(1, 12));
               for (int b = 0; b < len; b++) begin
                  logic [63:0] d;
                  repeat ($urandom_range(0, 2)) begin
                     @(posedge aclk);
                     #1;
                  end
                  d = {rand_lane(), rand_lane()};
                  model_beat(d, b == len - 1);
                  send_beat(d, b == len - 1);
               end
            end
            prod_done = 1'b1;
         end
         begin
            int cyc = 0;
            exp_t e;
            while ((!prod_done || exp_q.size() > 0) && cyc < RAND_CYC) begin
               @(posedge aclk);
               #1;
               m_axis_tready = ($urandom_range(0, 3) != 0);
               @(negedge aclk);
               cyc++;
               if (m_axis_tvalid && m_axis_tready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL rnd_unexpected actual=%0h required=none", m_axis_tdata);
                  end else begin
                     e = exp_q.pop_front();
                     chk("rnd_data", 64'(m_axis_tdata), 64'(e.d));
                     chk("rnd_user", 64'(m_axis_tuser), 64'(e.u));
                  end
               end
            end
            if (cyc >= RAND_CYC) timeout_fail("rnd_consumer");
         end
      join
      chk("rnd_leftover", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
